inst_cache: RTL and testbench

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache.sv | 146 ++++++++++++++
 tb/tb_inst_cache.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with flop-based storage.
// Misses fill one whole line from physical memory in LINE_BEATS 64-bit beats.
module inst_cache #(
  parameter int unsigned S_INDEX    = 3,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic [31:0] mem_address,
  input  logic        flush,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic [31:0] pmem_address,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned NumSets = 1 << S_INDEX;
  localparam int unsigned OffW    = $clog2(LINE_BEATS * 8);
  localparam int unsigned WordW   = OffW - 2;
  localparam int unsigned TagW    = 32 - OffW - S_INDEX;
  localparam int unsigned LineW   = LINE_BEATS * 64;
  localparam int unsigned BeatW   = $clog2(LINE_BEATS);

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e             state_q, state_d;
  logic [NumSets-1:0] valid_q, valid_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [TagW-1:0]    fill_tag_q, fill_tag_d;
  logic [S_INDEX-1:0] fill_idx_q, fill_idx_d;
  logic               flush_pend_q, flush_pend_d;
  logic [15:0]        hit_q, hit_d, miss_q, miss_d;

  logic [TagW-1:0]    tag_q  [NumSets];
  logic [LineW-1:0]   data_q [NumSets];

  logic [TagW-1:0]    req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [WordW-1:0]   req_word;
  logic               flush_now, hit, beat_wr, last_beat;
  logic               unused_addr_bits;

  assign req_tag          = mem_address[31 -: TagW];
  assign req_idx          = mem_address[OffW +: S_INDEX];
  assign req_word         = mem_address[2 +: WordW];
  assign unused_addr_bits = ^mem_address[1:0];

  // A flush deferred from a fill behaves exactly like a flush arriving in idle.
  assign flush_now = flush | flush_pend_q;
  assign hit       = (state_q == StIdle) && mem_read && !flush_now &&
                     valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign beat_wr   = (state_q == StFill) && pmem_resp;
  assign last_beat = beat_wr && (beat_q == BeatW'(LINE_BEATS - 1));

  assign mem_resp     = hit;
  assign pmem_read    = (state_q == StFill);
  assign pmem_address = {fill_tag_q, fill_idx_q, {OffW{1'b0}}};
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;

  always_comb begin
    mem_rdata = '0;
    if (hit) begin
      mem_rdata = data_q[req_idx][{req_word, 5'b00000} +: 32];
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    beat_d       = beat_q;
    fill_tag_d   = fill_tag_q;
    fill_idx_d   = fill_idx_q;
    flush_pend_d = flush_pend_q;
    miss_d       = miss_q;
    hit_d        = hit_q + {15'd0, hit};

    unique case (state_q)
      StIdle: begin
        if (flush_now) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end else if (mem_read && !hit) begin
          fill_tag_d       = req_tag;
          fill_idx_d       = req_idx;
          // The old line is being overwritten beat by beat, so it must stop hitting now.
          valid_d[req_idx] = 1'b0;
          beat_d           = '0;
          miss_d           = miss_q + 16'd1;
          state_d          = StFill;
        end
      end
      StFill: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (beat_wr) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            valid_d[fill_idx_q] = 1'b1;
            beat_d              = '0;
            state_d             = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      beat_q       <= '0;
      fill_tag_q   <= '0;
      fill_idx_q   <= '0;
      flush_pend_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      beat_q       <= beat_d;
      fill_tag_q   <= fill_tag_d;
      fill_idx_q   <= fill_idx_d;
      flush_pend_q <= flush_pend_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (last_beat) begin
      tag_q[fill_idx_q] <= fill_tag_q;
    end
    if (beat_wr) begin
      data_q[fill_idx_q][{beat_q, 6'b000000} +: 64] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, hit stream, conflict, flushes,
// reset during fill and hit counter wrap, with hand-computed expectations.
module tb_inst_cache;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        flush;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  inst_cache #(
    .S_INDEX    (3),
    .LINE_BEATS (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .flush        (flush),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line 0x100 holds 0x1111.., 0x2222.., 0x3333.., 0x4444..; line 0x200 holds
  // {BEEF000k, C0DE000k} for beat k.
  function automatic logic [63:0] beat_val(input logic [31:0] base, input int k);
    if (base == 32'h0000_0100) return 64'h1111_1111_1111_1111 * 64'(k + 1);
    return {32'hBEEF_0000 | 32'(k), 32'hC0DE_0000 | 32'(k)};
  endfunction

  // Serve one 4-beat fill; 'gap' idle cycles precede each beat, flush pulses on beat flush_beat.
  task automatic fill_serve(input logic [31:0] base, input int gap, input int flush_beat);
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        check("fill_gap_rd", {31'd0, pmem_read}, 32'd1);
        tick();
      end
      check("fill_rd", {31'd0, pmem_read}, 32'd1);
      check("fill_addr", pmem_address, base);
      check("fill_no_resp", {31'd0, mem_resp}, 32'd0);
      pmem_resp  = 1'b1;
      pmem_rdata = beat_val(base, k);
      flush      = (k == flush_beat);
      tick();
      pmem_resp  = 1'b0;
      flush      = 1'b0;
    end
  endtask

  logic [31:0] stream_exp [8];

  initial begin
    stream_exp = '{32'h1111_1111, 32'h1111_1111, 32'h2222_2222, 32'h2222_2222,
                   32'h3333_3333, 32'h3333_3333, 32'h4444_4444, 32'h4444_4444};
    rst         = 1'b0;
    mem_read    = 1'b0;
    mem_address = 32'h0;
    flush       = 1'b0;
    pmem_rdata  = 64'h0;
    pmem_resp   = 1'b0;

    repeat (3) tick();
    check("rst_resp", {31'd0, mem_resp}, 32'd0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_pread", {31'd0, pmem_read}, 32'd0);
    check("rst_paddr", pmem_address, 32'h0);
    check("rst_hits", {16'd0, hit_count}, 32'd0);
    check("rst_miss", {16'd0, miss_count}, 32'd0);
    rst = 1'b1;
    tick();

    // Cold miss at 0x104
    mem_read    = 1'b1;
    mem_address = 32'h0000_0104;
    #1;
    check("cold_resp", {31'd0, mem_resp}, 32'd0);
    tick();
    check("cold_pread", {31'd0, pmem_read}, 32'd1);
    check("cold_paddr", pmem_address, 32'h0000_0100);
    check("cold_miss", {16'd0, miss_count}, 32'd1);
    fill_serve(32'h0000_0100, 0, -1);
    #1;
    check("cold_hit_resp", {31'd0, mem_resp}, 32'd1);
    check("cold_hit_data", mem_rdata, 32'h1111_1111);
    check("cold_pread_off", {31'd0, pmem_read}, 32'd0);
    tick();
    check("cold_hits", {16'd0, hit_count}, 32'd1);

    // Hit stream over the whole line
    for (int i = 0; i < 8; i++) begin
      mem_address = 32'h0000_0100 + 32'(4 * i);
      #1;
      check("stream_resp", {31'd0, mem_resp}, 32'd1);
      check("stream_data", mem_rdata, stream_exp[i]);
      tick();
    end
    mem_read = 1'b0;
    #1;
    check("stream_hits", {16'd0, hit_count}, 32'd9);
    check("idle_resp", {31'd0, mem_resp}, 32'd0);
    check("idle_rdata", mem_rdata, 32'h0);

    // Stray pmem_resp in idle must not disturb anything
    pmem_resp  = 1'b1;
    pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    pmem_resp   = 1'b0;
    mem_read    = 1'b1;
    mem_address = 32'h0000_0100;
    #1;
    check("stray_resp", {31'd0, mem_resp}, 32'd1);
    check("stray_data", mem_rdata, 32'h1111_1111);
    tick();
    mem_read = 1'b0;
    check("stray_miss", {16'd0, miss_count}, 32'd1);
    check("stray_hits", {16'd0, hit_count}, 32'd10);

    // Conflict miss at 0x204; request lines wander during the fill
    mem_read    = 1'b1;
    mem_address = 32'h0000_0204;
    #1;
    check("conf_resp", {31'd0, mem_resp}, 32'd0);
    tick();
    check("conf_pread", {31'd0, pmem_read}, 32'd1);
    check("conf_miss", {16'd0, miss_count}, 32'd2);
    mem_read    = 1'b0;
    mem_address = 32'h0000_0100;
    fill_serve(32'h0000_0200, 1, -1);
    mem_read    = 1'b1;
    mem_address = 32'h0000_0204;
    #1;
    check("conf_hit_resp", {31'd0, mem_resp}, 32'd1);
    check("conf_hit_data", mem_rdata, 32'hBEEF_0000);
    tick();
    mem_address = 32'h0000_0218;
    #1;
    check("conf_hit_data3", mem_rdata, 32'hC0DE_0003);
    tick();
    mem_address = 32'h0000_0100;
    #1;
    check("evict_resp", {31'd0, mem_resp}, 32'd0);
    tick();
    check("evict_paddr", pmem_address, 32'h0000_0100);
    check("evict_miss", {16'd0, miss_count}, 32'd3);
    check("evict_hits", {16'd0, hit_count}, 32'd12);
    fill_serve(32'h0000_0100, 0, -1);
    mem_address = 32'h0000_010C;
    #1;
    check("refill_data", mem_rdata, 32'h2222_2222);
    tick();

    // Flush in idle: no response, no fill, line gone afterwards
    mem_address = 32'h0000_0100;
    flush       = 1'b1;
    #1;
    check("iflush_resp", {31'd0, mem_resp}, 32'd0);
    check("iflush_rdata", mem_rdata, 32'h0);
    tick();
    flush = 1'b0;
    check("iflush_nofill", {31'd0, pmem_read}, 32'd0);
    check("iflush_miss", {16'd0, miss_count}, 32'd3);
    #1;
    check("iflush_after", {31'd0, mem_resp}, 32'd0);
    tick();
    check("iflush_refill", {31'd0, pmem_read}, 32'd1);
    check("iflush_miss2", {16'd0, miss_count}, 32'd4);

    // Flush during fill, on the second beat
    mem_read = 1'b0;
    fill_serve(32'h0000_0100, 0, 1);
    #1;
    check("fflush_done", {31'd0, pmem_read}, 32'd0);
    tick();
    mem_read = 1'b1;
    #1;
    check("fflush_resp", {31'd0, mem_resp}, 32'd0);
    tick();
    check("fflush_pread", {31'd0, pmem_read}, 32'd1);
    check("fflush_miss", {16'd0, miss_count}, 32'd5);
    mem_read = 1'b0;
    fill_serve(32'h0000_0100, 0, -1);
    mem_read    = 1'b1;
    mem_address = 32'h0000_0118;
    #1;
    check("fflush_refill", mem_rdata, 32'h4444_4444);
    tick();

    // Reset in the middle of a fill
    mem_address = 32'h0000_0204;
    #1;
    check("rfill_resp", {31'd0, mem_resp}, 32'd0);
    tick();
    check("rfill_pread", {31'd0, pmem_read}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = beat_val(32'h0000_0200, k);
      tick();
      pmem_resp  = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("rfill_pread_drop", {31'd0, pmem_read}, 32'd0);
    check("rfill_miss_clr", {16'd0, miss_count}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rfill_after_resp", {31'd0, mem_resp}, 32'd0);
    tick();
    check("rfill_refetch", {31'd0, pmem_read}, 32'd1);
    check("rfill_paddr", pmem_address, 32'h0000_0200);
    check("rfill_miss", {16'd0, miss_count}, 32'd1);
    fill_serve(32'h0000_0200, 0, -1);
    #1;
    check("rfill_hit", mem_rdata, 32'hBEEF_0000);

    // Hit counter wraps after 65536 hits
    repeat (65535) tick();
    check("wrap_ffff", {16'd0, hit_count}, 32'h0000_FFFF);
    tick();
    check("wrap_zero", {16'd0, hit_count}, 32'h0);
    mem_read = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
